// File: rtl/trax_move_commit.sv
// Trax move-commit engine: validates a proposed placement, fetches the four
// neighbours, runs the legality checker and commits or rejects the tile.
module trax_move_commit #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int ROW_W       = 3,
    parameter int COL_W       = 3,
    parameter int CHK_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    input  logic [2:0]       req_tile,
    output logic             resp_valid,
    output logic             resp_accept,
    output logic [1:0]       resp_code,
    output logic             chk_start,
    output logic [2:0]       chk_up,
    output logic [2:0]       chk_down,
    output logic [2:0]       chk_right,
    output logic [2:0]       chk_left,
    input  logic             chk_done,
    input  logic [5:0]       chk_mask,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [2:0]       rd_tile,
    output logic [6:0]       move_count
);

    localparam int CNT_W = $clog2(CHK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHK_TIMEOUT);
    localparam logic [ROW_W:0] ROWS_X = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0] COLS_X = (COL_W + 1)'(COLS);
    localparam logic [6:0] MAX_MOVES = 7'(ROWS * COLS);

    localparam logic [1:0] RC_OK      = 2'd0;
    localparam logic [1:0] RC_BAD     = 2'd1;
    localparam logic [1:0] RC_ISOLATE = 2'd2;
    localparam logic [1:0] RC_ILLEGAL = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_VALIDATE,
        S_FETCH_U,
        S_FETCH_D,
        S_FETCH_R,
        S_FETCH_L,
        S_CHECK,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [2:0]       tile_q, tile_d;
    logic [2:0]       up_q, up_d;
    logic [2:0]       dn_q, dn_d;
    logic [2:0]       rt_q, rt_d;
    logic [2:0]       lf_q, lf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic             accept_q, accept_d;
    logic [6:0]       count_q, count_d;

    logic [2:0] board_q [ROWS][COLS];
    logic [2:0] board_d [ROWS][COLS];

    logic [ROW_W:0] f_row;
    logic [COL_W:0] f_col;
    logic [2:0]     f_tile;
    logic [2:0]     tile_idx;
    logic [7:0]     mask_ext;
    logic           bad_req;

    // Single board read port shared by VALIDATE (own cell) and the fetches;
    // the extra index bit makes row-1 at row 0 wrap to an off-board value.
    always_comb begin
        f_row = {1'b0, row_q};
        f_col = {1'b0, col_q};
        unique case (state_q)
            S_FETCH_U: f_row = {1'b0, row_q} - 1'b1;
            S_FETCH_D: f_row = {1'b0, row_q} + 1'b1;
            S_FETCH_R: f_col = {1'b0, col_q} + 1'b1;
            S_FETCH_L: f_col = {1'b0, col_q} - 1'b1;
            default: ;
        endcase
        f_tile = 3'd0;
        if (f_row < ROWS_X && f_col < COLS_X) begin
            f_tile = board_q[f_row[ROW_W-1:0]][f_col[COL_W-1:0]];
        end
    end

    always_comb begin
        rd_tile = 3'd0;
        if ({1'b0, rd_row} < ROWS_X && {1'b0, rd_col} < COLS_X) begin
            rd_tile = board_q[rd_row][rd_col];
        end
    end

    assign tile_idx = tile_q - 3'd1;
    assign mask_ext = {2'b00, chk_mask};
    assign bad_req  = ({1'b0, row_q} >= ROWS_X) || ({1'b0, col_q} >= COLS_X)
                   || (tile_q == 3'd0) || (tile_q == 3'd7) || (f_tile != 3'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            tile_q   <= '0;
            up_q     <= '0;
            dn_q     <= '0;
            rt_q     <= '0;
            lf_q     <= '0;
            cnt_q    <= '0;
            code_q   <= '0;
            accept_q <= 1'b0;
            count_q  <= '0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    board_q[r][c] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            tile_q   <= tile_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            rt_q     <= rt_d;
            lf_q     <= lf_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            accept_q <= accept_d;
            count_q  <= count_d;
            board_q  <= board_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        tile_d   = tile_q;
        up_d     = up_q;
        dn_d     = dn_q;
        rt_d     = rt_q;
        lf_d     = lf_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        accept_d = accept_q;
        count_d  = count_q;
        board_d  = board_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    row_d   = req_row;
                    col_d   = req_col;
                    tile_d  = req_tile;
                    state_d = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                if (bad_req) begin
                    code_d   = RC_BAD;
                    accept_d = 1'b0;
                    state_d  = S_RESP;
                end else if (count_q == 7'd0) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_FETCH_U;
                end
            end
            S_FETCH_U: begin
                up_d    = f_tile;
                state_d = S_FETCH_D;
            end
            S_FETCH_D: begin
                dn_d    = f_tile;
                state_d = S_FETCH_R;
            end
            S_FETCH_R: begin
                rt_d    = f_tile;
                state_d = S_FETCH_L;
            end
            S_FETCH_L: begin
                lf_d = f_tile;
                if ({up_q, dn_q, rt_q, f_tile} == 12'd0) begin
                    code_d   = RC_ISOLATE;
                    accept_d = 1'b0;
                    state_d  = S_RESP;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (chk_done) begin
                    if (mask_ext[tile_idx]) begin
                        state_d = S_WRITE;
                    end else begin
                        code_d   = RC_ILLEGAL;
                        accept_d = 1'b0;
                        state_d  = S_RESP;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    // checker stays silent when no tile fits
                    code_d   = RC_ILLEGAL;
                    accept_d = 1'b0;
                    state_d  = S_RESP;
                end
            end
            S_WRITE: begin
                board_d[row_q][col_q] = tile_q;
                if (count_q != MAX_MOVES) begin
                    count_d = count_q + 7'd1;
                end
                code_d   = RC_OK;
                accept_d = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: begin
                up_d    = '0;
                dn_d    = '0;
                rt_d    = '0;
                lf_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        chk_start  = (state_q == S_CHECK);
    end

    assign resp_accept = accept_q;
    assign resp_code   = code_q;
    assign chk_up      = up_q;
    assign chk_down    = dn_q;
    assign chk_right   = rt_q;
    assign chk_left    = lf_q;
    assign move_count  = count_q;

endmodule

// File: doc/trax_move_commit.md
# trax_move_commit

Move-commit engine for the Trax board: accepts a proposed tile placement, reads the four neighbouring cells from its internal board store, and drives the tile-legality checker with them. It waits for the checker's allowed-tile mask, then either writes the tile into the board or rejects the move. It is the board-side counterpart that feeds `up/down/left/right` tiles into the checker and consumes its `tile_type`/`endsignal` result.

## Interface
- `ROWS`, 8: board rows (row 0 = top).
- `COLS`, 8: board columns (col 0 = left).
- `ROW_W`, 3: row index width.
- `COL_W`, 3: column index width.
- `CHK_TIMEOUT`, 15: maximum number of WAIT cycles for `chk_done`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: move request valid.
- `req_ready` out 1: high only in IDLE; a request transfers when `req_valid && req_ready`.
- `req_row` in ROW_W / `req_col` in COL_W: target cell.
- `req_tile` in 3: tile code (0 = empty, 1 slash_down, 2 slash_up, 3 plus_vrt, 4 plus_hz, 5 backslash_up, 6 backslash_down, 7 invalid).
- `resp_valid` out 1: one-cycle response pulse.
- `resp_accept` out 1: 1 means the move was written.
- `resp_code` out 2: 0 ok; 1 bad request (out of range, tile 0/7, or cell occupied); 2 not adjacent to any tile; 3 illegal (mask bit clear or checker timeout).
- `chk_start` out 1: one-cycle start pulse to the checker.
- `chk_up`, `chk_down`, `chk_right`, `chk_left` out 3 each: neighbour codes presented to the checker.
- `chk_done` in 1: checker `endsignal`.
- `chk_mask` in 6: checker `tile_type`; bit t-1 set means tile t is allowed.
- `rd_row` in ROW_W / `rd_col` in COL_W / `rd_tile` out 3: combinational display read port. Out-of-range reads return 0.
- `move_count` out 7: number of tiles placed, saturating at ROWS*COLS.

## Operation
- Board store: ROWS×COLS×3-bit registers, all cleared on reset.
- Neighbour coordinates:
  - up = (row-1, col), down = (row+1, col), left = (row, col-1), right = (row, col+1).
  - Any coordinate off the board reads as 0 (empty).
- FSM states:
  - IDLE: `req_ready`=1. On transfer, latch row, col and tile, then go to VALIDATE.
  - VALIDATE: fail if row ≥ ROWS, col ≥ COLS, tile ∈ {0,7}, or the cell is non-zero → RESP with code 1. Else if `move_count`==0 → WRITE (first move: any tile, any cell). Else → FETCH_U.
  - FETCH_U → FETCH_D → FETCH_R → FETCH_L: one board read per cycle, each latched into the corresponding `chk_*` register.
  - After FETCH_L: if all four neighbours are 0 → RESP with code 2. Else → CHECK.
  - CHECK: `chk_start`=1 for exactly this cycle; clear the timeout counter; → WAIT.
  - WAIT: sample `chk_done` each cycle.
    - `chk_done`=1 and `chk_mask[tile-1]`=1 → WRITE.
    - `chk_done`=1 and the mask bit is clear → RESP with code 3.
    - Counter reaches CHK_TIMEOUT with no `chk_done` → RESP with code 3. This path is required: the checker never raises `endsignal` when no tile is legal.
  - WRITE: board[row][col] ← tile; `move_count` += 1 (saturating); → RESP with code 0.
  - RESP: `resp_valid`=1; `resp_accept`=(code==0); → IDLE.
- `chk_up/down/right/left` hold stable from the end of FETCH_L through WAIT. They return to 0 in IDLE.
- `chk_done` is ignored in every state except WAIT, including a `chk_done` that arrives in the same cycle as `chk_start`.
- `resp_code` and `resp_accept` hold their last values after RESP until the next RESP.

## Timing
- Reset values: state IDLE, board all 0, `move_count` 0, `resp_valid` 0, `resp_accept` 0, `resp_code` 0, `chk_start` 0, all `chk_*` tile outputs 0. `req_ready` is 1 in the first cycle after reset deasserts.
- Reset asserted mid-operation aborts the move: no write, no `resp_valid`, board cleared.
- Latency, with the request accepted at edge N:
  - Code 1 response: `resp_valid` in cycle N+2.
  - First move: WRITE in N+2, `resp_valid` in N+3.
  - Checked move: FETCH in N+2..N+5, `chk_start` in N+6, WAIT from N+7.
  - If `chk_done` is seen in WAIT cycle k: WRITE in k+1 and `resp_valid` in k+2 (accept), or `resp_valid` in k+1 (reject).
  - Timeout: `resp_valid` CHK_TIMEOUT+1 cycles after the first WAIT cycle.
- Throughput: one move in flight. `req_ready` is 0 from the cycle after a transfer until IDLE is re-entered.
- `rd_tile` reflects a WRITE in the cycle after the WRITE edge.

## Test plan
- Reset, then request (3,3,tile 2) → `resp_valid` 3 cycles later with accept=1, code 0; `rd_tile`(3,3)=2; `move_count`=1.
- With (3,3)=2, request (3,3,tile 4) → code 1, no write. Request (5,5,4) → code 2, and `chk_start` never pulses.
- With (3,3)=2, request (3,4,4): `chk_left`=2 with the other three outputs 0 during WAIT. Checker returns done with mask 6'b001010 → accept; `rd_tile`(3,4)=4; `move_count`=2.
- Same setup, checker returns mask 6'b000001 → code 3 and the board is unchanged. Checker holds done low → code 3 exactly CHK_TIMEOUT+1 cycles after the first WAIT cycle.
- Corner request (0,0,1) with (0,1) occupied → `chk_up`=`chk_left`=0 (off-board reads as empty). `chk_done` pulsed together with `chk_start` is ignored.
- Assert `reset` during WAIT → no `resp_valid`, board cleared, `move_count`=0, `req_ready`=1 on the next cycle.
